// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes N_DIG 3-bit digit codes onto one shared seven-segment decoder input.
// Latency: all outputs registered (one cycle after the state change); loaded data shows from the next frame boundary.
// Backpressure: none; load is always accepted and the last load before a boundary wins.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   en              scan enable; low freezes the scan position and turns every digit off
//   load            strobe that captures digits_in (digit k at [3k+2:3k]) and blank_in into the pending buffer
//   load_ack        pulse on the frame boundary where the pending buffer is copied into the active buffer
//   digit_code      code of the digit being scanned, to the decoder input
//   digit_sel       active-low one-hot digit enable (all ones = all off)
//   frame_done      pulse on the first cycle of every new frame
module seg_scan_ctrl #(
    parameter int N_DIG = 8,
    parameter int DWELL = 1000,
    parameter int GAP   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [3*N_DIG-1:0] digits_in,
    input  logic [N_DIG-1:0]   blank_in,
    output logic               load_ack,
    output logic [2:0]         digit_code,
    output logic [N_DIG-1:0]   digit_sel,
    output logic               frame_done
);

    localparam int TMAX = (GAP > DWELL) ? GAP : DWELL;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int IW   = $clog2(N_DIG);

    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);

    typedef enum logic {
        S_GAP  = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [TW-1:0]           timer, timer_nxt;
    logic                    boundary;
    logic                    apply;

    logic [N_DIG-1:0][2:0]   act_codes, act_codes_nxt;
    logic [N_DIG-1:0]        act_blank, act_blank_nxt;
    logic [N_DIG-1:0][2:0]   pend_codes;
    logic [N_DIG-1:0]        pend_blank;
    logic                    pend_vld;

    logic [N_DIG-1:0]        sel_nxt;
    logic [2:0]              code_nxt;

    // Scan sequencing: timer counts cycles spent in the current state.
    // While en is low nothing advances, so no boundary can fire.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        timer_nxt = timer;
        boundary  = 1'b0;
        if (en) begin
            case (state)
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        state_nxt = S_SHOW;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (timer == DWELL_LAST) begin
                        state_nxt = S_GAP;
                        timer_nxt = '0;
                        if (idx == IDX_LAST) begin
                            idx_nxt  = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_GAP;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Pending data is promoted only on the wrap back to digit 0, so a frame
    // is never drawn from a mix of old and new data.
    assign apply = boundary & pend_vld;

    always_comb begin
        act_codes_nxt = act_codes;
        act_blank_nxt = act_blank;
        if (apply) begin
            act_codes_nxt = pend_codes;
            act_blank_nxt = pend_blank;
        end
    end

    // Outputs are computed from next-state values so the registered outputs
    // line up with the state they describe. The active buffer and idx only
    // change on GAP entry, so digit_code holds steady through GAP and SHOW.
    always_comb begin
        sel_nxt = '1;
        if (en && (state_nxt == S_SHOW) && !act_blank_nxt[idx_nxt]) begin
            sel_nxt[idx_nxt] = 1'b0;
        end
        code_nxt = act_codes_nxt[idx_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_GAP;
            idx        <= '0;
            timer      <= '0;
            act_codes  <= '0;
            act_blank  <= '1;
            pend_codes <= '0;
            pend_blank <= '0;
            pend_vld   <= 1'b0;
            digit_sel  <= '1;
            digit_code <= '0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            timer      <= timer_nxt;
            act_codes  <= act_codes_nxt;
            act_blank  <= act_blank_nxt;
            // A load on the boundary cycle refills pending after the old
            // contents were promoted, so pend_vld stays set.
            if (load) begin
                pend_codes <= digits_in;
                pend_blank <= blank_in;
                pend_vld   <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
            digit_sel  <= sel_nxt;
            digit_code <= code_nxt;
            load_ack   <= apply;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DW    = 3;
    localparam int GP    = 1;
    localparam int P     = DW + GP;
    localparam int FRAME = N * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [11:0] digits_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load_ack;
    logic [2:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        frame_done;

    seg_scan_ctrl #(.N_DIG(N), .DWELL(DW), .GAP(GP)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .blank_in   (blank_in),
        .load_ack   (load_ack),
        .digit_code (digit_code),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the frame counted in enabled cycles;
    // digit and phase follow from plain division.
    int          m_pos;
    logic [11:0] m_act, m_pend;
    logic [3:0]  m_act_blank, m_pend_blank;
    logic        m_pvld;
    logic [3:0]  exp_sel;
    logic [2:0]  exp_code;
    logic        exp_fd, exp_ack;

    typedef struct {
        int         rep;
        logic       en;
        logic       load;
        logic [11:0] dig;
        logic [3:0] blank;
        logic [3:0] sel;
        logic [2:0] code;
        logic       fd;
        logic       ack;
    } vec_t;

    vec_t tbl [11];

    int acks, lit, bad, d2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_pos        = 0;
        m_act        = '0;
        m_act_blank  = '1;
        m_pend       = '0;
        m_pend_blank = '0;
        m_pvld       = 1'b0;
        exp_sel      = '1;
        exp_code     = '0;
        exp_fd       = 1'b0;
        exp_ack      = 1'b0;
    endfunction

    function automatic void model_edge();
        int dig, ph;
        exp_fd  = 1'b0;
        exp_ack = 1'b0;
        if (en) begin
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) begin
                exp_fd = 1'b1;
                if (m_pvld) begin
                    m_act       = m_pend;
                    m_act_blank = m_pend_blank;
                    m_pvld      = 1'b0;
                    exp_ack     = 1'b1;
                end
            end
        end
        if (load) begin
            m_pend       = digits_in;
            m_pend_blank = blank_in;
            m_pvld       = 1'b1;
        end
        dig      = m_pos / P;
        ph       = m_pos % P;
        exp_sel  = '1;
        if (en && ph >= GP && !m_act_blank[dig]) exp_sel[dig] = 1'b0;
        exp_code = m_act[3*dig +: 3];
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_sel",  32'(digit_sel),  32'(exp_sel));
        chk("model_code", 32'(digit_code), 32'(exp_code));
        chk("model_fd",   32'(frame_done), 32'(exp_fd));
        chk("model_ack",  32'(load_ack),   32'(exp_ack));
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (m_pos != target && guard < 40);
        if (m_pos != target) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to: position %0d, required %0d", m_pos, target);
        end
    endtask

    initial begin
        // Frame right after reset: load {3,2,1,0} on the first edge, shown from the second frame.
        tbl[0]  = '{1,  1'b1, 1'b1, 12'h688, 4'h0, 4'hF, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{14, 1'b1, 1'b0, 12'h000, 4'h0, 4'hF, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1,  1'b1, 1'b0, 12'h000, 4'h0, 4'hF, 3'd0, 1'b1, 1'b1};
        tbl[3]  = '{3,  1'b1, 1'b0, 12'h000, 4'h0, 4'hE, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1,  1'b1, 1'b0, 12'h000, 4'h0, 4'hF, 3'd1, 1'b0, 1'b0};
        tbl[5]  = '{3,  1'b1, 1'b0, 12'h000, 4'h0, 4'hD, 3'd1, 1'b0, 1'b0};
        tbl[6]  = '{1,  1'b1, 1'b0, 12'h000, 4'h0, 4'hF, 3'd2, 1'b0, 1'b0};
        tbl[7]  = '{3,  1'b1, 1'b0, 12'h000, 4'h0, 4'hB, 3'd2, 1'b0, 1'b0};
        tbl[8]  = '{1,  1'b1, 1'b0, 12'h000, 4'h0, 4'hF, 3'd3, 1'b0, 1'b0};
        tbl[9]  = '{3,  1'b1, 1'b0, 12'h000, 4'h0, 4'h7, 3'd3, 1'b0, 1'b0};
        tbl[10] = '{1,  1'b1, 1'b0, 12'h000, 4'h0, 4'hF, 3'd0, 1'b1, 1'b0};

        model_reset();
        #12;
        chk("reset_sel",  32'(digit_sel),  32'hF);
        chk("reset_code", 32'(digit_code), 32'h0);
        chk("reset_ack",  32'(load_ack),   32'h0);
        chk("reset_fd",   32'(frame_done), 32'h0);
        rst = 1'b0;

        for (int r = 0; r < 11; r++) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                en        = tbl[r].en;
                load      = tbl[r].load;
                digits_in = tbl[r].dig;
                blank_in  = tbl[r].blank;
                step();
                chk("tbl_sel",  32'(digit_sel),  32'(tbl[r].sel));
                chk("tbl_code", 32'(digit_code), 32'(tbl[r].code));
                chk("tbl_fd",   32'(frame_done), 32'(tbl[r].fd));
                chk("tbl_ack",  32'(load_ack),   32'(tbl[r].ack));
            end
        end
        load = 1'b0;

        // Two loads in one frame: only the second is ever displayed.
        acks = 0;
        load = 1'b1; digits_in = 12'hB6D; blank_in = 4'h0;
        step(); acks += int'(load_ack);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin step(); acks += int'(load_ack); end
        load = 1'b1; digits_in = 12'hFFF;
        step(); acks += int'(load_ack);
        load = 1'b0;
        for (int k = 0; k < 20 && m_pos != 0; k++) begin step(); acks += int'(load_ack); end
        chk("two_load_acks", 32'(acks), 32'd1);
        lit = 0; bad = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (digit_sel != 4'hF) begin
                lit++;
                if (digit_code != 3'd7) bad++;
            end
        end
        chk("two_load_lit", 32'(lit), 32'd12);
        chk("two_load_not7", 32'(bad), 32'd0);

        // Blank digit 2.
        load = 1'b1; digits_in = 12'h688; blank_in = 4'b0100;
        step();
        load = 1'b0;
        run_to(0);
        lit = 0; d2 = 0;
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (digit_sel != 4'hF) lit++;
            if (digit_sel[2] == 1'b0) d2++;
        end
        chk("blank_lit", 32'(lit), 32'd9);
        chk("blank_d2",  32'(d2),  32'd0);

        // Freeze mid-SHOW of digit 1, with a load accepted while frozen.
        run_to(5);
        chk("d1_lit", 32'(digit_sel), 32'hD);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            load = (k == 3);
            digits_in = 12'hD63; blank_in = 4'h0;
            step();
            chk("freeze_sel",  32'(digit_sel),  32'hF);
            chk("freeze_code", 32'(digit_code), 32'd1);
        end
        load = 1'b0; en = 1'b1;
        step(); chk("resume_sel1", 32'(digit_sel), 32'hD);
        step(); chk("resume_sel2", 32'(digit_sel), 32'hD);
        step(); chk("resume_gap",  32'(digit_sel), 32'hF);

        // Load coincident with the frame boundary.
        run_to(0);
        load = 1'b1; digits_in = 12'h531; blank_in = 4'h0;
        step();
        load = 1'b0;
        run_to(15);
        load = 1'b1; digits_in = 12'h0EF; blank_in = 4'h0;
        step();
        load = 1'b0;
        chk("coinc_ack",  32'(load_ack),   32'd1);
        chk("coinc_fd",   32'(frame_done), 32'd1);
        chk("coinc_code", 32'(digit_code), 32'd1);
        run_to(0);
        chk("coinc_ack2",  32'(load_ack),   32'd1);
        chk("coinc_code2", 32'(digit_code), 32'd7);

        // Random enable/load traffic against the model.
        for (int k = 0; k < 300; k++) begin
            en        = ($urandom_range(0, 9) != 0);
            load      = ($urandom_range(0, 7) == 0);
            digits_in = 12'($urandom);
            blank_in  = 4'($urandom_range(0, 15));
            step();
        end
        en = 1'b1; load = 1'b0;

        // Asynchronous reset mid-SHOW discards pending data.
        load = 1'b1; digits_in = 12'hFFF; blank_in = 4'h0;
        step();
        load = 1'b0;
        run_to(6);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sel",  32'(digit_sel),  32'hF);
        chk("midrst_code", 32'(digit_code), 32'h0);
        chk("midrst_ack",  32'(load_ack),   32'h0);
        chk("midrst_fd",   32'(frame_done), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        acks = 0; lit = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            acks += int'(load_ack);
            if (digit_sel != 4'hF) lit++;
        end
        chk("post_rst_acks", 32'(acks), 32'd0);
        chk("post_rst_lit",  32'(lit),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
